// File: rtl/btn_evt_pkg.sv
// btn_evt_pkg -- shared constants and helpers for the button/switch event block.
//
// Holds the bit-field positions of the read/write register word and the
// sticky-flag update helper used by every flag group.
package btn_evt_pkg;

  localparam int NB = 4;  // number of buttons and of switches

  // Register word layout
  localparam int PRESS_LSB      = 0;
  localparam int REL_LSB        = 4;
  localparam int LP_LSB         = 8;
  localparam int BTN_LSB        = 12;
  localparam int SWI_LSB        = 16;
  localparam int SWC_LSB        = 20;
  localparam int IRQ_EN_BIT     = 31;
  localparam int IRQ_EN_LD_BIT  = 31;
  localparam int IRQ_EN_VAL_BIT = 30;

  // Sticky flag update: clear the masked bits, then OR in new events, so an
  // event arriving in the same cycle as its clear leaves the flag set.
  function automatic logic [NB-1:0] sticky_next(input logic [NB-1:0] cur,
                                                 input logic [NB-1:0] clr,
                                                 input logic [NB-1:0] evt);
    return (cur & ~clr) | evt;
  endfunction

endpackage

// File: rtl/btn_evt_lp_cnt.sv
// lp_cnt -- long-press hold counter for one button.
//
// Counts clk cycles while btn is high, clears when btn is low and saturates
// at LP_CYCLES. lp_evt is high for the single cycle whose clock edge moves
// the counter onto LP_CYCLES, so it fires once per press.
//
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : counting enable (low until the first cycle after reset)
//   btn       : debounced button level, active-high
//   lp_evt    : long-press event, valid at the next clock edge
module lp_cnt #(
  parameter int LP_CYCLES = 50_000_000,
  parameter int CNT_W     = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic btn,
  output logic lp_evt
);

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(LP_CYCLES);
  localparam logic [CNT_W-1:0] LP_PRE = CNT_W'(LP_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!btn) begin
      cnt <= '0;
    end else if (en && (cnt != LP_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign lp_evt = en & btn & (cnt == LP_PRE);

endmodule

// File: rtl/btn_evt.sv
// btn_evt -- button/switch edge event register with sticky flags and IRQ.
//
// Detects press/release edges on btn_in and any change on swi_in, latches
// them in write-1-to-clear sticky flags and raises a registered level
// interrupt when enabled. Optional long-press detection is compiled in when
// the macro BTN_EVT_LONGPRESS_EN is defined; otherwise lp_f reads 0.
//
// Bus: ack = stb, zero-wait. A read (stb & ~we) returns
//   {irq_en, 7'b0, swc_f, swi_in, btn_in, lp_f, rel_f, press_f}
// and has no side effects. A write clears flags with data_in[11:0] and
// data_in[23:20], and loads irq_en from data_in[30] when data_in[31] is set.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   stb, we         : bus strobe, write enable
//   data_in/out     : 32-bit write/read data
//   ack             : bus acknowledge
//   btn_in, swi_in  : debounced synchronised buttons / switches
//   irq             : level interrupt request
module btn_evt
  import btn_evt_pkg::*;
#(
  parameter int LP_CYCLES = 50_000_000,
  parameter int CNT_W     = 26
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb,
  input  logic          we,
  input  logic [31:0]   data_in,
  output logic [31:0]   data_out,
  output logic          ack,
  input  logic [NB-1:0] btn_in,
  input  logic [NB-1:0] swi_in,
  output logic          irq
);

  // primed is low until the first clock after reset; that clock only loads
  // the prev registers so inputs held through reset produce no events.
  logic          primed;
  logic [NB-1:0] prev_btn, prev_swi;
  logic [NB-1:0] press_f, rel_f, lp_f, swc_f;
  logic          irq_en;

  logic          wr;
  logic [NB-1:0] press_evt, rel_evt, swc_evt;
  logic [NB-1:0] press_clr, rel_clr, swc_clr;

  assign wr        = stb & we;
  assign press_evt = primed ? (btn_in & ~prev_btn) : '0;
  assign rel_evt   = primed ? (~btn_in & prev_btn) : '0;
  assign swc_evt   = primed ? (swi_in ^ prev_swi)  : '0;
  assign press_clr = wr ? data_in[PRESS_LSB +: NB] : '0;
  assign rel_clr   = wr ? data_in[REL_LSB +: NB]   : '0;
  assign swc_clr   = wr ? data_in[SWC_LSB +: NB]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed   <= 1'b0;
      prev_btn <= '0;
      prev_swi <= '0;
      press_f  <= '0;
      rel_f    <= '0;
      swc_f    <= '0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      primed   <= 1'b1;
      prev_btn <= btn_in;
      prev_swi <= swi_in;
      press_f  <= sticky_next(press_f, press_clr, press_evt);
      rel_f    <= sticky_next(rel_f, rel_clr, rel_evt);
      swc_f    <= sticky_next(swc_f, swc_clr, swc_evt);
      if (wr && data_in[IRQ_EN_LD_BIT]) begin
        irq_en <= data_in[IRQ_EN_VAL_BIT];
      end
      irq      <= irq_en & (|{press_f, rel_f, lp_f, swc_f});
    end
  end

  logic unused_bits;

`ifdef BTN_EVT_LONGPRESS_EN
  logic [NB-1:0] lp_evt;
  logic [NB-1:0] lp_clr;

  assign lp_clr = wr ? data_in[LP_LSB +: NB] : '0;

  for (genvar i = 0; i < NB; i++) begin : g_lp
    lp_cnt #(
      .LP_CYCLES (LP_CYCLES),
      .CNT_W     (CNT_W)
    ) u_lp_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (primed),
      .btn    (btn_in[i]),
      .lp_evt (lp_evt[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_f <= '0;
    end else begin
      lp_f <= sticky_next(lp_f, lp_clr, lp_evt);
    end
  end

  assign unused_bits = ^{data_in[29:24], data_in[19:12]};
`else
  assign lp_f = '0;

  assign unused_bits = ^{data_in[29:24], data_in[19:12], data_in[11:8],
                         LP_CYCLES[0], CNT_W[0]};
`endif

  assign ack = stb;

  always_comb begin
    data_out = '0;
    if (stb && !we && !rst) begin
      data_out[PRESS_LSB +: NB] = press_f;
      data_out[REL_LSB +: NB]   = rel_f;
      data_out[LP_LSB +: NB]    = lp_f;
      data_out[BTN_LSB +: NB]   = btn_in;
      data_out[SWI_LSB +: NB]   = swi_in;
      data_out[SWC_LSB +: NB]   = swc_f;
      data_out[IRQ_EN_BIT]      = irq_en;
    end
  end

endmodule

// File: doc/btn_evt.md
BTN_EVT -- requirements
Module: btn_evt

Interface
REQ-001 SHALL have parameter LP_CYCLES, default 50_000_000, giving the long-press hold threshold in clk cycles; legal range is 2 or more.
REQ-002 SHALL have parameter CNT_W, default 26, giving the long-press counter width; CNT_W SHALL satisfy 2**CNT_W > LP_CYCLES.
REQ-003 SHALL have ports clk, input, 1 bit: the single system clock.
REQ-004 SHALL have ports rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have ports stb, input, 1 bit: IO bus strobe.
REQ-006 SHALL have ports we, input, 1 bit: write enable.
REQ-007 SHALL have ports data_in, input, 32 bits: write data.
REQ-008 SHALL have ports data_out, output, 32 bits: read data.
REQ-009 SHALL have ports ack, output, 1 bit: bus acknowledge.
REQ-010 SHALL have ports btn_in, input, 4 bits: debounced, synchronised buttons from the LSB block, active-high.
REQ-011 SHALL have ports swi_in, input, 4 bits: debounced, synchronised switches from the LSB block.
REQ-012 SHALL have ports irq, output, 1 bit: level interrupt request.

Function
REQ-013 SHALL register btn_in and swi_in into prev registers every cycle.
- Press event: btn_in=1 and prev=0.
- Release event: btn_in=0 and prev=1.
- Switch-change event: swi_in differs from prev.
REQ-014 SHALL set sticky flags on each event at the clock edge where the event is detected; flags are visible on data_out from the following cycle.
- press_f[3:0], rel_f[3:0], swc_f[3:0].
REQ-015 SHALL define read data as follows, with ack=stb and one-cycle zero-wait access:
- data_out = {irq_en, 7'b0, swc_f, swi_in, btn_in, lp_f, rel_f, press_f}, bit 31 = irq_en.
- data_out SHALL be 32'b0 unless stb=1 and we=0.
REQ-016 SHALL make reads free of side effects.
REQ-017 SHALL handle writes (stb=1, we=1) as follows:
- data_in[11:0] and data_in[23:20] are write-1-to-clear masks for press_f, rel_f, lp_f and swc_f respectively.
- If data_in[31]=1, irq_en is loaded from data_in[30].
REQ-018 SHALL give a new event priority over a clear of the same bit in the same cycle, so the flag ends up set.
REQ-019 SHALL drive irq = irq_en and the OR of all sticky flags, registered, so irq rises one cycle after the first flag sets.
REQ-020 SHALL give no special treatment to bits not listed in REQ-015 or REQ-017; they are ignored on write and read as 0.

Reset
REQ-021 SHALL, on rst=1, asynchronously clear prev, all flags, irq_en, irq and the long-press counters.
REQ-022 SHALL drive data_out=0 during rst, while ack continues to follow stb.
REQ-023 SHALL load prev from the live inputs on the first clock after rst deasserts, with no event generated on that clock, so a button held through reset produces no press event.

Configuration
REQ-024 SHALL compile long-press detection in when macro BTN_EVT_LONGPRESS_EN is defined:
- Each button has a CNT_W-bit counter that clears on release and increments while pressed.
- The counter saturates at LP_CYCLES.
- lp_f[i] sets exactly once per press, in the cycle the counter reaches LP_CYCLES.
REQ-025 SHALL, when BTN_EVT_LONGPRESS_EN is undefined, instantiate no counters, tie lp_f to 0, ignore its clear bits, and leave all other behaviour identical.

Structure
REQ-026 SHALL place the following in shared package btn_evt_pkg:
- Bit-field position constants: PRESS_LSB=0, REL_LSB=4, LP_LSB=8, BTN_LSB=12, SWI_LSB=16, SWC_LSB=20, IRQ_EN_BIT=31, IRQ_EN_LD_BIT=31, IRQ_EN_VAL_BIT=30.
REQ-027 SHALL implement one counter per button as sub-module lp_cnt, instantiated four times, and only under BTN_EVT_LONGPRESS_EN.

Verification
REQ-028 SHALL cover: btn_in 0000->0001 -> press_f=0001 in the next-cycle read; irq stays 0 with irq_en=0.
REQ-029 SHALL cover: write 0xC000_0000 then press btn2 -> irq=1 one cycle after press_f[2] sets; write 0x0000_0004 -> press_f=0 and irq drops the next cycle.
REQ-030 SHALL cover: a btn1 press edge coincident with a write of 0x0000_0002 -> press_f[1] reads 1.
REQ-031 SHALL cover: with LP_CYCLES=16 and the macro defined, hold btn3 for 40 cycles -> lp_f[3] sets once at cycle 16 and is not re-set after a W1C clear while still held; release -> rel_f[3]=1.
REQ-032 SHALL cover: swi_in toggled 0000->1010 -> swc_f=1010 and the swi field reads 1010; rst asserted mid-hold -> all flags 0 and no press event after release of rst.
REQ-033 SHALL cover: macro undefined, same stimulus as REQ-031 -> lp_f stays 0 and everything else matches.
